lane_seg_top_sdiv_26s_10ns_16_seq: RTL and testbench

- Sequential radix-2 restoring divider; the inverse of the 16s x 10ns -> 26 product multiplier.
- Divides a 26-bit signed dividend by a 10-bit unsigned divisor, giving a 16-bit signed quotient and an 11-bit signed remainder.
- Used in lane_seg post-processing to normalise accumulated products (e.g. mean/scale recovery).
- Valid/ready handshake on input and output; one division in flight at a time.

---
 rtl/lane_seg_div_pkg.sv | 21 ++
 rtl/lane_seg_div_step.sv | 24 ++
 rtl/lane_seg_top_sdiv_26s_10ns_16_seq.sv | 121 ++++++++++++
 tb/tb_lane_seg_top_sdiv_26s_10ns_16_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_seg_div_pkg.sv
// Shared types and constants for the lane_seg sequential signed divider.
package lane_seg_div_pkg;

  localparam int DIV_NUM_W = 26;
  localparam int DIV_DEN_W = 10;
  localparam int DIV_Q_W   = 16;
  localparam int DIV_R_W   = 11;

  localparam logic signed [DIV_Q_W-1:0] QMAX = 16'sh7FFF;
  localparam logic signed [DIV_Q_W-1:0] QMIN = 16'sh8000;

  localparam logic [4:0] ITER_LAST = 5'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/lane_seg_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// when it fits, and report the resulting quotient bit.
`default_nettype none

module lane_seg_div_step
  import lane_seg_div_pkg::*;
(
  input  logic [DIV_R_W-1:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIV_DEN_W-1:0] den,
  output logic [DIV_R_W-1:0]   rem_out,
  output logic                 q_bit
);

  logic [DIV_R_W:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, den});
  // The difference is always < den when taken, so modulo-2^11 arithmetic is exact.
  assign rem_out = q_bit ? (shifted[DIV_R_W-1:0] - {1'b0, den}) : shifted[DIV_R_W-1:0];

endmodule

`default_nettype wire

// File: rtl/lane_seg_top_sdiv_26s_10ns_16_seq.sv
// Sequential 26s / 10u radix-2 restoring divider with valid/ready handshakes.
// Build option SDIV_SAT_EN: clamp the quotient to 16 bits instead of wrapping.
`default_nettype none

module lane_seg_top_sdiv_26s_10ns_16_seq
  import lane_seg_div_pkg::*;
#(
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 16,
  parameter int rem_WIDTH  = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout_q,
  output logic [rem_WIDTH-1:0]  dout_r,
  output logic                  div_by_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  div_state_t state, state_next;

  // mag holds the dividend magnitude; quotient bits shift in as dividend bits shift out.
  logic [DIV_NUM_W-1:0] mag;
  logic [DIV_DEN_W-1:0] den;
  logic [DIV_R_W-1:0]   prem;
  logic [DIV_R_W-1:0]   rem_next;
  logic                 q_bit;
  logic                 neg;
  logic [4:0]           cnt;

  lane_seg_div_step u_step (
    .rem_in  (prem),
    .bit_in  (mag[DIV_NUM_W-1]),
    .den     (den),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (din1 == '0) ? DONE : CALC;
      end
      CALC:    if (cnt == 5'd0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mag         <= '0;
      den         <= '0;
      prem        <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      dout_q      <= '0;
      dout_r      <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg  <= din0[DIV_NUM_W-1];
            mag  <= din0[DIV_NUM_W-1] ? (-din0) : din0;
            den  <= din1;
            prem <= '0;
            cnt  <= ITER_LAST;
            if (din1 == '0) begin
              div_by_zero <= 1'b1;
              dout_q      <= din0[DIV_NUM_W-1] ? QMIN : QMAX;
              dout_r      <= din0[DIV_R_W-1:0];
            end
          end
        end
        CALC: begin
          mag  <= {mag[DIV_NUM_W-2:0], q_bit};
          prem <= rem_next;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        FIX: begin
          dout_r <= neg ? (-prem) : prem;
`ifdef SDIV_SAT_EN
          if (!neg) dout_q <= (mag > 26'd32767) ? QMAX : mag[DIV_Q_W-1:0];
          else      dout_q <= (mag > 26'd32768) ? QMIN : (-mag[DIV_Q_W-1:0]);
`else
          dout_q <= neg ? (-mag[DIV_Q_W-1:0]) : mag[DIV_Q_W-1:0];
`endif
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lane_seg_top_sdiv_26s_10ns_16_seq.sv
// Self-checking bench: C-semantics reference model plus directed literal cases.
`default_nettype none

module tb_lane_seg_top_sdiv_26s_10ns_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [25:0] din0;
  logic [9:0]  din1;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dout_q;
  logic [10:0] dout_r;
  logic        div_by_zero;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  lane_seg_top_sdiv_26s_10ns_16_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .din0        (din0),
    .din1        (din1),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout_q      (dout_q),
    .dout_r      (dout_r),
    .div_by_zero (div_by_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial forever #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Truncating signed division, then 16-bit wrap or clamp.
  function automatic void model(input logic [25:0] a, input logic [9:0] b,
                                output logic [15:0] q, output logic [10:0] r,
                                output logic z);
    longint sa, qq, rr;
    sa = longint'($signed(a));
    if (b == 10'd0) begin
      z = 1'b1;
      q = (sa < 0) ? 16'h8000 : 16'h7FFF;
      r = a[10:0];
    end else begin
      z  = 1'b0;
      qq = sa / longint'(b);
      rr = sa % longint'(b);
`ifdef SDIV_SAT_EN
      if (qq > 32767) qq = 32767;
      if (qq < -32768) qq = -32768;
`endif
      q = qq[15:0];
      r = rr[10:0];
    end
  endfunction

  // Cycle monitor: tracks the single in-flight job and checks every output.
  initial begin
    int n = 0;
    int acc = 0;
    int lat = 0;
    bit busy = 1'b0;
    bit ev;
    logic [15:0] eq;
    logic [10:0] er;
    logic ez;
    eq = '0; er = '0; ez = 1'b0;
    forever begin
      @(negedge ap_clk);
      #1;
      n++;
      if (!ap_rst_n) begin
        busy = 1'b0;
      end else begin
        ev = busy && (n >= acc + 1 + lat);
        chk("mon_in_ready", {31'd0, in_ready}, {31'd0, !busy});
        chk("mon_out_valid", {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
          chk("mon_q", {16'd0, dout_q}, {16'd0, eq});
          chk("mon_r", {21'd0, dout_r}, {21'd0, er});
          chk("mon_dbz", {31'd0, div_by_zero}, {31'd0, ez});
        end
        if (ev && out_ready) begin
          busy = 1'b0;
        end else if (!busy && in_valid) begin
          model(din0, din1, eq, er, ez);
          lat  = ez ? 1 : 28;
          acc  = n;
          busy = 1'b1;
        end
      end
    end
  end

  task automatic run(input logic [25:0] a, input logic [9:0] b, input int stall,
                     input bit lit, input logic [15:0] lq, input logic [10:0] lr,
                     input logic lz, input int llat);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!in_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    din0 = a; din1 = b; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge ap_clk);
    in_valid = 1'b0;
    din0 = 26'($urandom);
    n = 1;
    while (n < 100) begin
      #1;
      if (out_valid) break;
      @(negedge ap_clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    if (lit) begin
      chk("lit_q", {16'd0, dout_q}, {16'd0, lq});
      chk("lit_r", {21'd0, dout_r}, {21'd0, lr});
      chk("lit_dbz", {31'd0, div_by_zero}, {31'd0, lz});
      chk("lit_latency", n - 1, llat);
    end
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge ap_clk);
        in_valid = i[0];
        din0 = 26'($urandom);
        din1 = 10'($urandom);
      end
      #1;
      if (lit) chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
      @(negedge ap_clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge ap_clk);
      #1;
      if (lit) chk("stall_single_result", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] a;
    logic [9:0]  b;
    ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {16'd0, dout_q}, 32'd0);
    chk("rst_r", {21'd0, dout_r}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    #2 ap_rst_n = 1'b1;

    run(26'd1000, 10'd7, 0, 1'b1, 16'd142, 11'd6, 1'b0, 28);
    run(-26'sd1000, 10'd7, 0, 1'b1, 16'hFF72, 11'h7FA, 1'b0, 28);
    run(-26'sd1, 10'd1023, 0, 1'b1, 16'h0000, 11'h7FF, 1'b0, 28);
`ifdef SDIV_SAT_EN
    run(26'h1FFFFFF, 10'd1, 0, 1'b1, 16'h7FFF, 11'd0, 1'b0, 28);
    run(26'h2000000, 10'd1, 0, 1'b1, 16'h8000, 11'd0, 1'b0, 28);
`else
    run(26'h1FFFFFF, 10'd1, 0, 1'b1, 16'hFFFF, 11'd0, 1'b0, 28);
    run(26'h2000000, 10'd1, 0, 1'b1, 16'h0000, 11'd0, 1'b0, 28);
`endif
    run(-26'sd500, 10'd0, 0, 1'b1, 16'h8000, 11'h60C, 1'b1, 1);
    run(26'd12345, 10'd100, 10, 1'b1, 16'd123, 11'd45, 1'b0, 28);

    // Reset while CALC holds counter 12; the in-flight result must vanish.
    @(negedge ap_clk);
    din0 = 26'd1000; din1 = 10'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (13) @(posedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_q", {16'd0, dout_q}, 32'd0);
    chk("arst_r", {21'd0, dout_r}, 32'd0);
    chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge ap_clk);
    #3 ap_rst_n = 1'b1;
    run(26'd1000, 10'd7, 0, 1'b1, 16'd142, 11'd6, 1'b0, 28);

    for (int k = 0; k < 30; k++) begin
      a = 26'($urandom);
      if (k % 3 == 0) a = 26'($signed(15'($urandom)));
      b = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
      run(a, b, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
          1'b0, 16'd0, 11'd0, 1'b0, 0);
    end

    repeat (3) @(negedge ap_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
